// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: a one-entry holding buffer in front of a 16-bit SPI
// shifter for a serial DAC. Frame = {2'b00, pd_mode, value_in}, MSB first.
// SCK idles high and the DAC samples on its falling edge. MOSI only moves on
// SCK rising edges (or at frame start). CS is held high for CS_IDLE cycles
// between frames.
module dac_spi_serializer #(
    parameter int SCK_HALF = 1,   // 1..255 clk cycles per SCK half-period
    parameter int CS_IDLE  = 2    // 1..255 clk cycles of CS high between frames
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] value_in,
    input  logic [1:0]  pd_mode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_IDLE - 1);

    state_t      state, state_nxt;
    logic        buf_full;
    logic        rdy_en;      // holds in_ready low for the first edge after reset
    logic [13:0] buf_data;
    logic [15:0] sreg;
    logic [7:0]  half_cnt;
    logic [7:0]  gap_cnt;
    logic [3:0]  bit_cnt;
    logic        load;        // move the buffer into the shifter and start a frame
    logic        finish;      // low half of bit 0 just ended
    logic        half_end;
    logic        bit_end;
    logic        gap_end;
    logic        accept;

    assign half_end = (half_cnt == HALF_LAST);
    assign bit_end  = half_end && !spi_sck;
    assign gap_end  = (gap_cnt == GAP_LAST);
    assign accept   = in_valid && in_ready;

    assign in_ready = rdy_en && !buf_full;
    assign busy     = (state != IDLE) || buf_full;
    // sreg is zero whenever CS is high, so MOSI rests low between frames
    assign spi_mosi = sreg[15];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and frame start/end strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_end && (bit_cnt == 4'd15)) begin
                    state_nxt = GAP;
                    finish    = 1'b1;
                end
            end
            GAP: begin
                if (gap_end) begin
                    if (buf_full) begin
                        state_nxt = SHIFT;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding buffer: filled on accept, emptied when a frame starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en   <= 1'b0;
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (load) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
                buf_data <= {pd_mode, value_in};
            end
        end
    end

    // Shifter, SCK/CS generation and the half-period, bit and gap counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg       <= '0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            spi_cs     <= 1'b1;
            spi_sck    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= finish;
            if (load) begin
                sreg     <= {2'b00, buf_data};
                spi_cs   <= 1'b0;
                spi_sck  <= 1'b1;
                half_cnt <= '0;
                bit_cnt  <= '0;
            end else if (finish) begin
                sreg    <= '0;
                spi_cs  <= 1'b1;
                spi_sck <= 1'b1;
                gap_cnt <= '0;
            end else if (state == SHIFT) begin
                if (half_end) begin
                    half_cnt <= '0;
                    if (spi_sck) begin
                        spi_sck <= 1'b0;
                    end else begin
                        // rising SCK: present the next bit
                        spi_sck <= 1'b1;
                        bit_cnt <= bit_cnt + 4'd1;
                        sreg    <= {sreg[14:0], 1'b0};
                    end
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: two instances (default timing and
// SCK_HALF=3/CS_IDLE=4) share one stimulus stream. Each has a reference
// model that predicts frame start edges from the buffer/period rules, the
// per-cycle pin waveform derived from time since frame start, and a
// falling-edge receiver whose frames are matched against the model.
module tb_dac_spi_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] value_in = '0;
    logic [1:0]  pd_mode = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int SH        = (g == 0) ? 1 : 3;
        localparam int CI        = (g == 0) ? 2 : 4;
        localparam int SHIFT_LEN = 32 * SH;
        localparam int PERIOD    = SHIFT_LEN + CI;

        logic in_ready, spi_mosi, spi_sck, spi_cs, frame_done, busy;

        dac_spi_serializer #(.SCK_HALF(SH), .CS_IDLE(CI)) dut (
            .clk(clk), .rst(rst), .value_in(value_in), .pd_mode(pd_mode),
            .in_valid(in_valid), .in_ready(in_ready), .spi_mosi(spi_mosi),
            .spi_sck(spi_sck), .spi_cs(spi_cs), .frame_done(frame_done), .busy(busy)
        );

        // model state
        longint      cyc = 0;
        longint      last_start = -100000;
        longint      next_free = 0;
        bit          rdy = 1'b0;
        bit          bv = 1'b0;
        bit          pre_ready;
        logic [15:0] bdata = '0;
        logic [15:0] cur = '0;
        logic [15:0] sent_q[$];
        logic [15:0] rx_log[$];
        int          acc_cnt = 0;
        int          rx_cnt = 0;

        // Model: a frame starts at the first edge with a buffered sample once
        // the previous frame's period has elapsed; accepts need an empty buffer.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdy = 1'b0; bv = 1'b0;
                last_start = -100000; next_free = 0;
                sent_q.delete();
                acc_cnt = 0;
            end else begin
                pre_ready = rdy && !bv;
                cyc++;
                if (bv && cyc >= next_free) begin
                    last_start = cyc;
                    cur = bdata;
                    next_free = cyc + PERIOD;
                    bv = 1'b0;
                    sent_q.push_back(cur);
                end
                if (in_valid && pre_ready) begin
                    bv = 1'b1;
                    bdata = {2'b00, pd_mode, value_in};
                    acc_cnt++;
                end
                rdy = 1'b1;
            end
        end

        longint      t;
        bit          in_frame, e_cs, e_sck, e_mosi, e_fd, e_rdy, e_busy;
        bit          prev_sck = 1'b1, prev_cs = 1'b1;
        logic [15:0] rx_word = '0;
        int          rx_n = 0, low_n = 0;

        // Pin waveform check plus falling-edge receiver
        always @(negedge clk) begin
            t        = cyc - last_start;
            in_frame = (t >= 0) && (t < SHIFT_LEN);
            e_cs     = !in_frame;
            e_sck    = in_frame ? ((t % (2 * SH)) < SH) : 1'b1;
            e_mosi   = in_frame ? cur[15 - int'(t / (2 * SH))] : 1'b0;
            e_fd     = (t == SHIFT_LEN);
            e_rdy    = rdy && !bv;
            e_busy   = bv || ((t >= 0) && (t < PERIOD));
            chk($sformatf("pins%0d{cs,sck,mosi,fd,rdy,busy}", g),
                32'({spi_cs, spi_sck, spi_mosi, frame_done, in_ready, busy}),
                32'({e_cs, e_sck, e_mosi, e_fd, e_rdy, e_busy}));
            if (!rst) begin
                rx_n = 0; low_n = 0; rx_cnt = 0;
                prev_cs = 1'b1; prev_sck = 1'b1;
            end else begin
                if (!spi_cs) begin
                    low_n++;
                    if (prev_sck && !spi_sck) begin
                        rx_word = {rx_word[14:0], spi_mosi};
                        rx_n++;
                    end
                end
                if (spi_cs && !prev_cs) begin
                    chk($sformatf("bits%0d", g), 32'(rx_n), 32'd16);
                    chk($sformatf("cs_low%0d", g), 32'(low_n), 32'(SHIFT_LEN));
                    chk($sformatf("frame_queued%0d", g), 32'(sent_q.size() != 0), 32'd1);
                    if (sent_q.size() != 0)
                        chk($sformatf("frame%0d", g), 32'(rx_word), 32'(sent_q.pop_front()));
                    rx_log.push_back(rx_word);
                    rx_cnt++;
                    rx_n = 0; low_n = 0;
                end
                prev_cs = spi_cs; prev_sck = spi_sck;
            end
        end
    end

    // Present one sample and hold it until instance 0 takes it
    task automatic offer(input logic [1:0] pd, input logic [11:0] v, input string tag);
        int n = 0;
        pd_mode = pd; value_in = v; in_valid = 1'b1;
        while (!u[0].in_ready && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_wait"}, 32'(n < 300), 32'd1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_full_rdy"}, 32'(u[0].in_ready), 32'd0);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((u[0].busy || u[1].busy) && n < lim) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n < lim), 32'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        int lat, cs_lat, b0, b1, n;
        logic [11:0] v3 [3];
        logic [1:0]  p3 [3];
        v3[0] = 12'h123; v3[1] = 12'h456; v3[2] = 12'h789;
        p3[0] = 2'd1;    p3[1] = 2'd2;    p3[2] = 2'd0;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pins", 32'({u[0].spi_cs, u[0].spi_sck, u[0].spi_mosi, u[0].frame_done,
                             u[0].in_ready, u[0].busy}), 32'b110000);
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("rdy_after_rst", 32'(u[0].in_ready), 32'd1);

        // single sample, fixed latency
        b0 = u[0].rx_log.size(); b1 = u[1].rx_log.size();
        pd_mode = 2'd0; value_in = 12'hA5C; in_valid = 1'b1;
        lat = 0; cs_lat = 0;
        do begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            lat++;
            if (!u[0].spi_cs && cs_lat == 0) cs_lat = lat;
        end while (!u[0].frame_done && lat < 200);
        chk("cs_fall_lat", 32'(cs_lat), 32'd2);
        chk("frame_done_lat", 32'(lat - 1), 32'd33);
        wait_idle(500);
        chk("a5c_n0", 32'(u[0].rx_log.size() - b0), 32'd1);
        chk("a5c_0", 32'(u[0].rx_log[b0]), 32'h0A5C);
        chk("a5c_1", 32'(u[1].rx_log[b1]), 32'h0A5C);

        // power-down bits in the frame
        b0 = u[0].rx_log.size();
        offer(2'b11, 12'hFFF, "pd3");
        wait_idle(500);
        chk("pd3_frame", 32'(u[0].rx_log[b0]), 32'h3FFF);

        // three samples back to back with in_valid kept up
        b0 = u[0].rx_log.size();
        for (int k = 0; k < 3; k++) offer(p3[k], v3[k], "b2b");
        wait_idle(1000);
        chk("b2b_n", 32'(u[0].rx_log.size() - b0), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("b2b_order", 32'(u[0].rx_log[b0 + k]), 32'({2'b00, p3[k], v3[k]}));

        // offer while the buffer is full: must be ignored
        b0 = u[0].rx_log.size();
        offer(2'd0, 12'h111, "w");
        offer(2'd0, 12'h222, "x");
        pd_mode = 2'd1; value_in = 12'h333; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("y_rdy", 32'(u[0].in_ready), 32'd0);
        in_valid = 1'b0;
        wait_idle(1000);
        chk("y_n", 32'(u[0].rx_log.size() - b0), 32'd2);
        chk("y_w", 32'(u[0].rx_log[b0]), 32'h0111);
        chk("y_x", 32'(u[0].rx_log[b0 + 1]), 32'h0222);

        // reset in the middle of a frame
        b0 = u[0].rx_log.size();
        offer(2'd2, 12'hABC, "abort");
        n = 0;
        while (u[0].spi_cs && n < 100) begin
            @(negedge clk); n++;
        end
        chk("abort_cs_wait", 32'(n < 100), 32'd1);
        repeat (15) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_pins", 32'({u[0].spi_cs, u[0].spi_sck, u[0].spi_mosi, u[0].frame_done,
                               u[0].in_ready, u[0].busy}), 32'b110000);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        chk("abort_no_frame", 32'(u[0].rx_log.size() - b0), 32'd0);
        offer(2'd1, 12'h5A5, "post");
        wait_idle(500);
        chk("post_n", 32'(u[0].rx_log.size() - b0), 32'd1);
        chk("post_frame", 32'(u[0].rx_log[b0]), 32'h15A5);

        // random traffic, both instances checked by their models
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            value_in = 12'($urandom);
            pd_mode  = 2'($urandom);
        end
        in_valid = 1'b0;
        wait_idle(4000);
        chk("count0", 32'(u[0].rx_cnt), 32'(u[0].acc_cnt));
        chk("count1", 32'(u[1].rx_cnt), 32'(u[1].acc_cnt));
        chk("pending0", 32'(u[0].sent_q.size()), 32'd0);
        chk("pending1", 32'(u[1].sent_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
